// File: rtl/bcd_seven_seg_scanner.sv
// Time-multiplexed 3-digit 7-segment scanner for a BCD hundreds/tens/ones value.
// Digits are snapshotted once per scan frame; leading zeros, guard time and bad nibbles are handled.
module bcd_seven_seg_scanner #(
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD_CYCLES   = 1000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int             CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  TERM    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD_C = CW'(GUARD_CYCLES);
  localparam logic [6:0]     SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic [2:0]     AN_OFF  = ACTIVE_LOW_AN ? 3'b111 : 3'b000;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    r_sh_h;
  logic [3:0]    r_sh_t;
  logic [3:0]    r_sh_o;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;
  logic          r_frame_tick;

  logic          w_term;
  logic          w_guard;
  logic          w_blank;
  logic [3:0]    w_digit;
  logic [2:0]    w_an_sel;
  logic [6:0]    w_glyph;
  logic [6:0]    w_seg_logic;
  logic [2:0]    w_an_logic;
  logic [6:0]    w_seg_next;
  logic [2:0]    w_an_next;

  assign w_term = (r_cnt == TERM);

  // A zero-length guard would make the compare constant-false, so it is elided.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_cnt < GUARD_C);
    end
  endgenerate

  always_comb begin
    w_digit  = r_sh_o;
    w_an_sel = 3'b001;
    w_blank  = 1'b0;
    case (r_slot)
      2'd1: begin
        w_digit  = r_sh_t;
        w_an_sel = 3'b010;
        w_blank  = BLANK_LEADING && (r_sh_h == 4'd0) && (r_sh_t == 4'd0);
      end
      2'd2: begin
        w_digit  = r_sh_h;
        w_an_sel = 3'b100;
        w_blank  = BLANK_LEADING && (r_sh_h == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_glyph = 7'h40;
    case (w_digit)
      4'd0: w_glyph = 7'h3F;
      4'd1: w_glyph = 7'h06;
      4'd2: w_glyph = 7'h5B;
      4'd3: w_glyph = 7'h4F;
      4'd4: w_glyph = 7'h66;
      4'd5: w_glyph = 7'h6D;
      4'd6: w_glyph = 7'h7D;
      4'd7: w_glyph = 7'h07;
      4'd8: w_glyph = 7'h7F;
      4'd9: w_glyph = 7'h6F;
      default: w_glyph = 7'h40;
    endcase
  end

  always_comb begin
    w_seg_logic = w_glyph;
    w_an_logic  = w_an_sel;
    if (w_guard || w_blank) begin
      w_seg_logic = 7'h00;
      w_an_logic  = 3'b000;
    end
    w_seg_next = ACTIVE_LOW_SEG ? ~w_seg_logic : w_seg_logic;
    w_an_next  = ACTIVE_LOW_AN ? ~w_an_logic : w_an_logic;
  end

  // Inputs are only sampled on the reload edge, so a mid-frame change cannot tear the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_slot       <= 2'd0;
      r_sh_h       <= 4'd0;
      r_sh_t       <= 4'd0;
      r_sh_o       <= 4'd0;
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_tick <= 1'b0;
      if (w_term) begin
        r_cnt <= '0;
        if (r_slot == 2'd2) begin
          r_slot       <= 2'd0;
          r_sh_h       <= hundreds;
          r_sh_t       <= tens;
          r_sh_o       <= ones;
          r_frame_tick <= 1'b1;
        end else begin
          r_slot <= r_slot + 2'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
module tb_bcd_seven_seg_scanner;

    localparam int R  = 4;
    localparam int G  = 1;
    localparam int FR = 3 * R;
    localparam int WAIT_LIMIT = 4 * FR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;

    bcd_seven_seg_scanner #(
        .REFRESH_DIV   (R),
        .GUARD_CYCLES  (G),
        .ACTIVE_LOW_SEG(1'b0),
        .ACTIVE_LOW_AN (1'b0),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [2:0] an;
        logic       tick;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] hist[4096];
    bit          prev_rst = 1'b1;
    int          rel = 0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tab[10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        return tab[d];
    endfunction

    function automatic exp_t model(input int r);
        exp_t        e;
        int          m, f, w, slot, c;
        logic [3:0]  dig[3];
        logic [11:0] sh;
        bit          lit;
        m    = r - 1;
        f    = m / FR;
        w    = m % FR;
        slot = w / R;
        c    = w % R;
        sh   = (f == 0) ? 12'h000 : hist[f * FR - 1];
        dig[2] = sh[11:8];
        dig[1] = sh[7:4];
        dig[0] = sh[3:0];
        lit  = !((slot == 2) && (dig[2] == 4'd0)) &&
               !((slot == 1) && (dig[2] == 4'd0) && (dig[1] == 4'd0));
        e.tick = (w == FR - 1);
        e.cyc  = 0;
        if ((c < G) || !lit) begin
            e.seg = 7'h00;
            e.an  = 3'b000;
        end else begin
            e.seg = glyph(dig[slot]);
            e.an  = 3'(1 << slot);
        end
        return e;
    endfunction

    task automatic step(input bit r, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        exp_t e;
        @(negedge clk);
        if (prev_rst) begin
            rel    = 0;
            e.seg  = 7'h00;
            e.an   = 3'b000;
            e.tick = 1'b0;
        end else begin
            rel = rel + 1;
            e   = model(rel);
        end
        e.cyc = cyc;
        sb.push_back(e);
        reset     = r;
        hundreds  = h;
        tens      = t;
        ones      = o;
        hist[rel] = {h, t, o};
        prev_rst  = r;
        cyc++;
    endtask

    task automatic hold(input string name, input int n, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        $display("phase %s: H=%h T=%h O=%h for %0d cycles", name, h, t, o, n);
        repeat (n) step(1'b0, h, t, o);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (seg !== e.seg || an !== e.an || frame_tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL scan_out cyc=%0d seg/an/tick got %h/%b/%b required %h/%b/%b",
                             e.cyc, seg, an, frame_tick, e.seg, e.an, e.tick);
                end
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [3:0] h, t, o;
        int waited;
        $display("phase reset: held 3 cycles");
        repeat (3) step(1'b1, 4'd0, 4'd0, 4'd0);
        #2;
        if (seg !== 7'h00 || an !== 3'b000 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state seg/an/tick got %h/%b/%b required 00/000/0",
                     seg, an, frame_tick);
        end else begin
            $display("reset_state seg/an/tick %h/%b/%b ok", seg, an, frame_tick);
        end
        hold("zero_frame", 14, 4'd0, 4'd0, 4'd0);
        hold("h1_t2_o3", 30, 4'd1, 4'd2, 4'd3);
        hold("only_ones", 30, 4'd0, 4'd0, 4'd7);
        hold("tens_ones", 30, 4'd0, 4'd5, 4'd0);
        hold("before_change", 30, 4'd2, 4'd5, 4'd5);
        hold("after_change", 30, 4'd1, 4'd2, 4'd8);
        hold("invalid_ones", 30, 4'd0, 4'd0, 4'hC);
        hold("invalid_high", 30, 4'hF, 4'hA, 4'd9);

        $display("phase mid_hundreds_reset");
        waited = 0;
        do begin
            step(1'b0, 4'd4, 4'd5, 4'd6);
            waited++;
        end while (!(((rel + 1) % FR == 9) && (rel > FR)) && (waited < WAIT_LIMIT));
        if (!(((rel + 1) % FR == 9) && (rel > FR))) begin
            miscompares++;
            $display("FAIL mid_hundreds_wait expired after %0d cycles", waited);
        end
        step(1'b1, 4'd9, 4'd9, 4'd9);
        hold("after_reset", 30, 4'd9, 4'd9, 4'd9);

        $display("phase random: 400 cycles");
        h = 4'd0; t = 4'd0; o = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                o = 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 199) == 0), h, t, o);
        end
        hold("tail", 4, h, t, o);

        repeat (3) @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
